// File: rtl/mpsoc_msi_wb_pkg.sv
// mpsoc_msi_wb_pkg: shared Wishbone cycle-type constants, FSM states and burst address stepping
package mpsoc_msi_wb_pkg;

    localparam logic [2:0] CLASSIC = 3'b000;
    localparam logic [2:0] CONST   = 3'b001;
    localparam logic [2:0] INCR    = 3'b010;
    localparam logic [2:0] EOB     = 3'b111;

    localparam logic [1:0] LINEAR = 2'b00;
    localparam logic [1:0] WRAP4  = 2'b01;
    localparam logic [1:0] WRAP8  = 2'b10;
    localparam logic [1:0] WRAP16 = 2'b11;

    localparam int MAX_AW = 64;

    typedef enum logic [2:0] {IDLE, ACTIVE, GAP, BACKOFF, DONE} state_t;

    // Wrapping bursts only advance the beat-index bits; the mask spans N beats of DW/8 bytes.
    function automatic logic [MAX_AW-1:0] wb_next_adr(input logic [MAX_AW-1:0] adr,
                                                      input logic [2:0] cti,
                                                      input logic [1:0] bte,
                                                      input int unsigned dw);
        logic [MAX_AW-1:0] step, inc, mask;
        step = MAX_AW'(dw / 8);
        inc  = adr + step;
        mask = bte == WRAP4  ? (step << 2) - MAX_AW'(1) :
               bte == WRAP8  ? (step << 3) - MAX_AW'(1) :
               bte == WRAP16 ? (step << 4) - MAX_AW'(1) : '0;
        if (cti == CONST) return adr;
        return (cti == INCR && bte != LINEAR) ? ((adr & ~mask) | (inc & mask)) : inc;
    endfunction

endpackage

// File: rtl/mpsoc_msi_wb_adr_gen.sv
// mpsoc_msi_wb_adr_gen: combinational next-address and per-beat CTI/BTE generation
module mpsoc_msi_wb_adr_gen
    import mpsoc_msi_wb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int LW = 6
) (
    input  logic [AW-1:0] adr,
    input  logic [2:0]    cti,
    input  logic [1:0]    bte,
    input  logic [LW-1:0] rem,
    output logic [AW-1:0] nxt_adr,
    output logic [2:0]    beat_cti,
    output logic [1:0]    beat_bte
);

    assign nxt_adr  = AW'(wb_next_adr(MAX_AW'(adr), cti, bte, DW));
    // rem is the number of beats still to go including the one being described
    assign beat_cti = cti == CLASSIC ? CLASSIC : rem == LW'(1) ? EOB : cti;
    assign beat_bte = cti == INCR ? bte : LINEAR;

endmodule

// File: rtl/mpsoc_msi_wb_burst_master.sv
// mpsoc_msi_wb_burst_master: Wishbone B3 burst master with wait-state insertion and bounded retry
module mpsoc_msi_wb_burst_master
    import mpsoc_msi_wb_pkg::*;
#(
    parameter int AW            = 32,
    parameter int DW            = 32,
    parameter int MAX_BURST_LEN = 32,
    parameter int WAIT_STATES   = 0,
    parameter int MAX_RETRIES   = 3,
    localparam int LW           = $clog2(MAX_BURST_LEN) + 1
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            cmd_valid_i,
    output logic            cmd_ready_o,
    input  logic [AW-1:0]   cmd_adr_i,
    input  logic            cmd_we_i,
    input  logic [DW/8-1:0] cmd_sel_i,
    input  logic [2:0]      cmd_cti_i,
    input  logic [1:0]      cmd_bte_i,
    input  logic [LW-1:0]   cmd_len_i,
    input  logic            wdat_valid_i,
    output logic            wdat_ready_o,
    input  logic [DW-1:0]   wdat_i,
    output logic            rdat_valid_o,
    output logic [DW-1:0]   rdat_o,
    output logic            done_o,
    output logic            err_o,
    output logic [AW-1:0]   wb_adr_o,
    output logic [DW-1:0]   wb_dat_o,
    output logic [DW/8-1:0] wb_sel_o,
    output logic            wb_we_o,
    output logic            wb_cyc_o,
    output logic            wb_stb_o,
    output logic [2:0]      wb_cti_o,
    output logic [1:0]      wb_bte_o,
    input  logic [DW-1:0]   wb_dat_i,
    input  logic            wb_ack_i,
    input  logic            wb_err_i,
    input  logic            wb_rty_i
);

    localparam int RW = $clog2(MAX_RETRIES + 1) + 1;

    state_t          state, state_n;
    logic            rdy_q, we_q, err_q;
    logic [AW-1:0]   adr_q;
    logic [DW/8-1:0] sel_q;
    logic [2:0]      cti_q, wb_cti_q;
    logic [1:0]      bte_q, wb_bte_q;
    logic [LW-1:0]   rem_q;
    logic [RW-1:0]   retries;
    logic [3:0]      gap_cnt;
    logic            idle, cyc, accept, last, err_hit, rty_hit, beat_ack, can_retry;
    logic [AW-1:0]   nxt_adr;
    logic [2:0]      beat_cti;
    logic [1:0]      beat_bte;

    // In IDLE the generator describes the first beat of the incoming command, otherwise the next beat.
    mpsoc_msi_wb_adr_gen #(.AW(AW), .DW(DW), .LW(LW)) u_adr_gen (
        .adr      (adr_q),
        .cti      (idle ? cmd_cti_i : cti_q),
        .bte      (idle ? cmd_bte_i : bte_q),
        .rem      (idle ? cmd_len_i : rem_q - LW'(1)),
        .nxt_adr  (nxt_adr),
        .beat_cti (beat_cti),
        .beat_bte (beat_bte)
    );

    assign idle         = state == IDLE;
    assign cyc          = state == ACTIVE || state == GAP;
    assign cmd_ready_o  = idle && rdy_q;
    assign accept       = cmd_ready_o && cmd_valid_i;
    assign last         = rem_q == LW'(1);
    assign can_retry    = retries < RW'(MAX_RETRIES);
    assign wb_stb_o     = state == ACTIVE && (!we_q || wdat_valid_i);
    assign err_hit      = wb_stb_o && wb_err_i;
    assign rty_hit      = wb_stb_o && wb_rty_i && !wb_err_i;
    assign beat_ack     = wb_stb_o && wb_ack_i && !wb_err_i && !wb_rty_i;
    assign wb_cyc_o     = cyc;
    assign wb_adr_o     = cyc ? adr_q : '0;
    assign wb_sel_o     = cyc ? sel_q : '0;
    assign wb_we_o      = cyc && we_q;
    assign wb_cti_o     = cyc ? wb_cti_q : '0;
    assign wb_bte_o     = cyc ? wb_bte_q : '0;
    assign wb_dat_o     = (state == ACTIVE && we_q) ? wdat_i : '0;
    assign wdat_ready_o = beat_ack && we_q;
    assign rdat_valid_o = beat_ack && !we_q;
    assign rdat_o       = rdat_valid_o ? wb_dat_i : '0;
    assign done_o       = state == DONE;
    assign err_o        = err_q;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
            rdy_q <= 1'b0;
        end else begin
            state <= state_n;
            rdy_q <= 1'b1;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = accept ? ACTIVE : IDLE;
            ACTIVE:  state_n = err_hit  ? DONE :
                               rty_hit  ? (can_retry ? BACKOFF : DONE) :
                               beat_ack ? (last ? DONE : (WAIT_STATES > 0 ? GAP : ACTIVE)) : ACTIVE;
            GAP:     state_n = gap_cnt == '0 ? ACTIVE : GAP;
            BACKOFF: state_n = ACTIVE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            adr_q    <= '0;
            sel_q    <= '0;
            we_q     <= 1'b0;
            cti_q    <= '0;
            bte_q    <= '0;
            wb_cti_q <= '0;
            wb_bte_q <= '0;
            rem_q    <= '0;
            retries  <= '0;
            gap_cnt  <= '0;
            err_q    <= 1'b0;
        end else if (accept) begin
            adr_q    <= cmd_adr_i;
            sel_q    <= cmd_sel_i;
            we_q     <= cmd_we_i;
            cti_q    <= cmd_cti_i;
            bte_q    <= cmd_bte_i;
            wb_cti_q <= beat_cti;
            wb_bte_q <= beat_bte;
            rem_q    <= cmd_len_i;
            retries  <= '0;
            err_q    <= 1'b0;
        end else if (state == ACTIVE) begin
            if (err_hit || (rty_hit && !can_retry)) begin
                err_q <= 1'b1;
            end else if (rty_hit) begin
                retries <= retries + RW'(1);
            end else if (beat_ack) begin
                rem_q    <= rem_q - LW'(1);
                adr_q    <= nxt_adr;
                wb_cti_q <= beat_cti;
                gap_cnt  <= 4'(WAIT_STATES - 1);
            end
        end else if (state == GAP) begin
            gap_cnt <= gap_cnt - 4'd1;
        end
    end

endmodule

// File: tb/tb_mpsoc_msi_wb_burst_master.sv
// tb_mpsoc_msi_wb_burst_master: scoreboard bench with a scripted Wishbone slave
module tb_mpsoc_msi_wb_burst_master;

    localparam int AW = 32, DW = 32, MBL = 32, WS = 2, MR = 3;
    localparam int LW = $clog2(MBL) + 1;

    logic            wb_clk_i = 1'b0;
    logic            wb_rst_i = 1'b1;
    logic            cmd_valid_i, cmd_ready_o, cmd_we_i;
    logic [AW-1:0]   cmd_adr_i;
    logic [DW/8-1:0] cmd_sel_i;
    logic [2:0]      cmd_cti_i;
    logic [1:0]      cmd_bte_i;
    logic [LW-1:0]   cmd_len_i;
    logic            wdat_valid_i, wdat_ready_o, rdat_valid_o, done_o, err_o;
    logic [DW-1:0]   wdat_i, rdat_o, wb_dat_o, wb_dat_i;
    logic [AW-1:0]   wb_adr_o;
    logic [DW/8-1:0] wb_sel_o;
    logic            wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i, wb_err_i, wb_rty_i;
    logic [2:0]      wb_cti_o;
    logic [1:0]      wb_bte_o;

    always #5 wb_clk_i = ~wb_clk_i;

    mpsoc_msi_wb_burst_master #(.AW(AW), .DW(DW), .MAX_BURST_LEN(MBL), .WAIT_STATES(WS), .MAX_RETRIES(MR)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_adr_i(cmd_adr_i), .cmd_we_i(cmd_we_i),
        .cmd_sel_i(cmd_sel_i), .cmd_cti_i(cmd_cti_i), .cmd_bte_i(cmd_bte_i), .cmd_len_i(cmd_len_i),
        .wdat_valid_i(wdat_valid_i), .wdat_ready_o(wdat_ready_o), .wdat_i(wdat_i),
        .rdat_valid_o(rdat_valid_o), .rdat_o(rdat_o), .done_o(done_o), .err_o(err_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
    );

    typedef struct {
        logic [31:0] adr;
        logic [2:0]  cti;
        logic [1:0]  bte;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] dat;
        int          period;
        int          bo;
    } beat_t;
    typedef struct {
        logic err;
        int   lat;
    } done_t;

    beat_t       exp_beats[$];
    logic [31:0] exp_rd[$];
    done_t       exp_done[$];
    int          n_chk = 0, n_fail = 0;

    // Scripted slave: acks every strobe, rty/err injected at a chosen beat index
    int          slv_idx = 0, rty_cnt = 0, stb_cnt = 0, widx = 0;
    int          err_at = -1, rty_at = -1, rty_max = 0, wlen = 0;
    logic        acc_pulse = 1'b0;
    logic [31:0] wmem [8];

    assign wb_rty_i     = wb_stb_o && slv_idx == rty_at && rty_cnt < rty_max;
    assign wb_err_i     = wb_stb_o && slv_idx == err_at;
    assign wb_ack_i     = wb_stb_o && !wb_rty_i;
    assign wb_dat_i     = 32'hD000_0000 | wb_adr_o;
    assign wdat_valid_i = widx < wlen;
    assign wdat_i       = wmem[widx[2:0]];

    always @(posedge wb_clk_i) begin
        acc_pulse <= cmd_valid_i && cmd_ready_o;
        if (cmd_valid_i && cmd_ready_o) begin
            slv_idx <= 0;
            rty_cnt <= 0;
            stb_cnt <= 0;
            widx    <= 0;
        end else begin
            if (wb_stb_o) stb_cnt <= stb_cnt + 1;
            if (wb_rty_i) rty_cnt <= rty_cnt + 1;
            else if (wb_ack_i && !wb_err_i) slv_idx <= slv_idx + 1;
            if (wdat_ready_o) widx <= widx + 1;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic flag(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: event missing or unexpected", nm);
    endtask

    task automatic push_beat(input logic [31:0] adr, input logic [2:0] cti, input logic [1:0] bte, input logic we,
                             input logic [3:0] sel, input logic [31:0] dat, input int period, input int bo);
        beat_t b;
        b.adr = adr; b.cti = cti; b.bte = bte; b.we = we; b.sel = sel; b.dat = dat; b.period = period; b.bo = bo;
        exp_beats.push_back(b);
        if (!we) exp_rd.push_back(32'hD000_0000 | adr);
    endtask

    task automatic push_done(input logic err, input int lat);
        done_t d;
        d.err = err; d.lat = lat;
        exp_done.push_back(d);
    endtask

    task automatic send(input logic [31:0] adr, input logic we, input logic [3:0] sel, input logic [2:0] cti,
                        input logic [1:0] bte, input int len);
        bit ok = 1'b0;
        @(negedge wb_clk_i);
        cmd_adr_i = adr; cmd_we_i = we; cmd_sel_i = sel; cmd_cti_i = cti; cmd_bte_i = bte;
        cmd_len_i = LW'(len); cmd_valid_i = 1'b1;
        for (int n = 0; n < 50 && !ok; n++) begin
            if (cmd_ready_o) ok = 1'b1;
            else @(negedge wb_clk_i);
        end
        if (!ok) flag("cmd_accept_timeout");
        @(posedge wb_clk_i);
        #1 cmd_valid_i = 1'b0;
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge wb_clk_i);
            if (done_o) seen = 1'b1;
        end
        if (!seen) flag("done_timeout");
    endtask

    // Monitor: pops the scoreboard whenever the DUT completes a beat, delivers read data or ends a command
    int    since_ack = 0, cyc_low = 0;
    beat_t mb;
    done_t md;
    always @(negedge wb_clk_i) begin
        if (wb_rst_i) begin
            since_ack = 0;
            cyc_low   = 0;
        end else begin
            if (acc_pulse) begin
                since_ack = 0;
                cyc_low   = 0;
            end
            since_ack++;
            if (!wb_cyc_o) cyc_low++;
            if (wb_stb_o && wb_ack_i && !wb_err_i && !wb_rty_i) begin
                if (exp_beats.size() == 0) flag("beat_unexpected");
                else begin
                    mb = exp_beats.pop_front();
                    chk("beat_adr", wb_adr_o, mb.adr);
                    chk("beat_cti", wb_cti_o, mb.cti);
                    chk("beat_bte", wb_bte_o, mb.bte);
                    chk("beat_we", wb_we_o, mb.we);
                    chk("beat_sel", wb_sel_o, mb.sel);
                    if (mb.we) chk("beat_wdat", wb_dat_o, mb.dat);
                    if (mb.period > 0) chk("beat_period", since_ack, mb.period);
                    chk("beat_cyc_low", cyc_low, mb.bo);
                end
                since_ack = 0;
                cyc_low   = 0;
            end
            if (rdat_valid_o) begin
                if (exp_rd.size() == 0) flag("rdat_unexpected");
                else chk("rdat", rdat_o, exp_rd.pop_front());
            end
            if (done_o) begin
                if (exp_done.size() == 0) flag("done_unexpected");
                else begin
                    md = exp_done.pop_front();
                    chk("done_err", err_o, md.err);
                    if (md.lat > 0) chk("done_latency", since_ack, md.lat);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w8 [8];
        logic [31:0] a;
        bit          hit;
        w8 = '{32'h218, 32'h21C, 32'h200, 32'h204, 32'h208, 32'h20C, 32'h210, 32'h214};
        cmd_valid_i = 1'b0; cmd_adr_i = '0; cmd_we_i = 1'b0; cmd_sel_i = '0;
        cmd_cti_i = '0; cmd_bte_i = '0; cmd_len_i = '0;
        repeat (3) @(negedge wb_clk_i);
        chk("rst_cmd_ready", cmd_ready_o, 0);
        chk("rst_cyc", wb_cyc_o, 0);
        chk("rst_stb", wb_stb_o, 0);
        chk("rst_adr", wb_adr_o, 0);
        chk("rst_cti", wb_cti_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_rdat_valid", rdat_valid_o, 0);
        wb_rst_i = 1'b0;
        #1 chk("ready_before_edge", cmd_ready_o, 0);
        @(posedge wb_clk_i);
        #1 chk("ready_after_edge", cmd_ready_o, 1);

        // Incrementing linear write, 4 beats
        wmem[0] = 32'hA0; wmem[1] = 32'hA1; wmem[2] = 32'hA2; wmem[3] = 32'hA3; wlen = 4;
        push_beat(32'h100, 3'b010, 2'b00, 1, 4'hF, 32'hA0, 0, 0);
        push_beat(32'h104, 3'b010, 2'b00, 1, 4'hF, 32'hA1, 3, 0);
        push_beat(32'h108, 3'b010, 2'b00, 1, 4'hF, 32'hA2, 3, 0);
        push_beat(32'h10C, 3'b111, 2'b00, 1, 4'hF, 32'hA3, 3, 0);
        push_done(0, 1);
        send(32'h100, 1, 4'hF, 3'b010, 2'b00, 4);
        wait_done();
        chk("incr_wr_pops", widx, 4);

        // Wrap-8 read starting mid-block
        wlen = 0;
        for (int i = 0; i < 8; i++)
            push_beat(w8[i], i == 7 ? 3'b111 : 3'b010, 2'b10, 0, 4'hF, 0, i == 0 ? 0 : 3, 0);
        push_done(0, 1);
        send(32'h218, 0, 4'hF, 3'b010, 2'b10, 8);
        wait_done();

        // Classic read: cti stays 000, bte forced to 00
        for (int i = 0; i < 3; i++) begin
            a = 32'h300 + 32'(4 * i);
            push_beat(a, 3'b000, 2'b00, 0, 4'h3, 0, i == 0 ? 0 : 3, 0);
        end
        push_done(0, 1);
        send(32'h300, 0, 4'h3, 3'b000, 2'b01, 3);
        wait_done();

        // One rty on beat 2 of a 4-beat read: 1-cycle backoff, restart at 0x404
        rty_at = 1; rty_max = 1;
        push_beat(32'h400, 3'b010, 2'b00, 0, 4'hF, 0, 0, 0);
        push_beat(32'h404, 3'b010, 2'b00, 0, 4'hF, 0, 5, 1);
        push_beat(32'h408, 3'b010, 2'b00, 0, 4'hF, 0, 3, 0);
        push_beat(32'h40C, 3'b111, 2'b00, 0, 4'hF, 0, 3, 0);
        push_done(0, 1);
        send(32'h400, 0, 4'hF, 3'b010, 2'b00, 4);
        wait_done();
        chk("retry_rty_count", rty_cnt, 1);

        // Retry exhaustion: fourth rty reports an error, no beat completes
        rty_at = 0; rty_max = 4;
        push_done(1, 0);
        send(32'h500, 0, 4'hF, 3'b010, 2'b00, 2);
        wait_done();
        chk("exhaust_rty_count", rty_cnt, 4);
        rty_at = -1; rty_max = 0;

        // err (with ack) on beat 1 of a write: no more strobes, no more pops
        err_at = 1;
        wmem[0] = 32'hB0; wmem[1] = 32'hB1; wmem[2] = 32'hB2; wmem[3] = 32'hB3; wlen = 4;
        push_beat(32'h600, 3'b010, 2'b00, 1, 4'hF, 32'hB0, 0, 0);
        push_done(1, 0);
        send(32'h600, 1, 4'hF, 3'b010, 2'b00, 4);
        wait_done();
        chk("err_wr_pops", widx, 1);
        chk("err_stb_cycles", stb_cnt, 2);
        repeat (3) @(negedge wb_clk_i);
        chk("err_sticky", err_o, 1);
        err_at = -1;

        // Reset during the gap after the second beat of a long read
        wlen = 0;
        push_beat(32'h700, 3'b010, 2'b00, 0, 4'hF, 0, 0, 0);
        push_beat(32'h704, 3'b010, 2'b00, 0, 4'hF, 0, 3, 0);
        send(32'h700, 0, 4'hF, 3'b010, 2'b00, 8);
        chk("err_cleared_on_accept", err_o, 0);
        hit = 1'b0;
        for (int n = 0; n < 60 && !hit; n++) begin
            @(negedge wb_clk_i);
            if (slv_idx == 2) hit = 1'b1;
        end
        if (!hit) flag("rst_burst_progress_timeout");
        chk("rst_pre_cyc", wb_cyc_o, 1);
        #1 wb_rst_i = 1'b1;
        #1;
        chk("rst_mid_cyc", wb_cyc_o, 0);
        chk("rst_mid_stb", wb_stb_o, 0);
        chk("rst_mid_adr", wb_adr_o, 0);
        chk("rst_mid_sel", wb_sel_o, 0);
        chk("rst_mid_cti", wb_cti_o, 0);
        chk("rst_mid_we", wb_we_o, 0);
        chk("rst_mid_ready", cmd_ready_o, 0);
        chk("rst_mid_done", done_o, 0);
        repeat (2) @(negedge wb_clk_i);
        wb_rst_i = 1'b0;

        // A fresh write after reset runs normally
        wmem[0] = 32'hC0; wmem[1] = 32'hC1; wlen = 2;
        push_beat(32'h800, 3'b010, 2'b00, 1, 4'hF, 32'hC0, 0, 0);
        push_beat(32'h804, 3'b111, 2'b00, 1, 4'hF, 32'hC1, 3, 0);
        push_done(0, 1);
        send(32'h800, 1, 4'hF, 3'b010, 2'b00, 2);
        wait_done();
        chk("post_rst_pops", widx, 2);

        repeat (3) @(negedge wb_clk_i);
        chk("left_beats", exp_beats.size(), 0);
        chk("left_rdat", exp_rd.size(), 0);
        chk("left_done", exp_done.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
